led_pulse_out: RTL and testbench



---
 rtl/led_pulse_out.sv | 136 +++++++++++++
 tb/tb_led_pulse_out.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/led_pulse_out.sv
// led_pulse_out
//
// Stretches single-cycle event pulses into human-visible, active-low indicator
// drive. Each channel holds its output low for ON_TICKS ticks per event, then
// high for GAP_TICKS ticks. Events that arrive while a channel is busy are
// counted (saturating at PEND_MAX) and replayed back-to-back after each gap.
//
// Parameters:
//   DIV       clocks per tick period (>= 2)
//   ON_TICKS  ticks the output is held low per event (>= 1)
//   GAP_TICKS ticks the output is held high after each ON interval (>= 1)
//   PEND_MAX  saturation value of the per-channel pending counter (>= 1)
//
// Ports:
//   CLK    system clock
//   RST    asynchronous, active-high reset
//   BIN    event pulses, one bit per channel; each high cycle is one event
//   nLOUT  registered active-low drive; 0 = indicator on

module led_pulse_out #(
   parameter int unsigned DIV       = 1250000,
   parameter int unsigned ON_TICKS  = 8,
   parameter int unsigned GAP_TICKS = 4,
   parameter int unsigned PEND_MAX  = 3
) (
   input  logic       CLK,
   input  logic       RST,
   input  logic [2:0] BIN,
   output logic [2:0] nLOUT
);

   localparam int unsigned TMAX = (ON_TICKS > GAP_TICKS) ? ON_TICKS : GAP_TICKS;
   localparam int unsigned TW   = $clog2(TMAX + 1);
   localparam int unsigned PW   = $clog2(PEND_MAX + 1);

   localparam logic [20:0]   CNT_LAST = 21'(DIV - 1);
   localparam logic [TW-1:0] T_ON     = TW'(ON_TICKS);
   localparam logic [TW-1:0] T_GAP    = TW'(GAP_TICKS);
   localparam logic [TW-1:0] T_ONE    = TW'(1);
   localparam logic [PW-1:0] P_MAX    = PW'(PEND_MAX);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      ON   = 2'd1,
      GAP  = 2'd2
   } state_t;

   logic [20:0]   cnt;
   logic          tick;
   state_t        state [3];
   logic [TW-1:0] tcnt  [3];
   logic [PW-1:0] pend  [3];

   // Shared tick generator: one pulse every DIV clocks.
   assign tick = (cnt == CNT_LAST);

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         cnt <= '0;
      end else if (tick) begin
         cnt <= '0;
      end else begin
         cnt <= cnt + 21'd1;
      end
   end

   // Per-channel sequencer; nLOUT is updated alongside the state so it is low
   // exactly while the channel is in ON.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         for (int i = 0; i < 3; i++) begin
            state[i] <= IDLE;
            tcnt[i]  <= '0;
            pend[i]  <= '0;
         end
         nLOUT <= 3'b111;
      end else begin
         for (int i = 0; i < 3; i++) begin
            case (state[i])
               IDLE: begin
                  if (BIN[i]) begin
                     state[i] <= ON;
                     tcnt[i]  <= T_ON;
                     nLOUT[i] <= 1'b0;
                  end
               end

               ON: begin
                  // An event on the ON-expiry edge is still queued.
                  if (BIN[i] && pend[i] != P_MAX) begin
                     pend[i] <= pend[i] + 1'b1;
                  end
                  if (tick) begin
                     if (tcnt[i] == T_ONE) begin
                        state[i] <= GAP;
                        tcnt[i]  <= T_GAP;
                        nLOUT[i] <= 1'b1;
                     end else begin
                        tcnt[i] <= tcnt[i] - T_ONE;
                     end
                  end
               end

               GAP: begin
                  if (tick && tcnt[i] == T_ONE) begin
                     if (pend[i] != '0 || BIN[i]) begin
                        state[i] <= ON;
                        tcnt[i]  <= T_ON;
                        nLOUT[i] <= 1'b0;
                        // A fresh event is consumed in place of a queued one.
                        if (!BIN[i]) begin
                           pend[i] <= pend[i] - 1'b1;
                        end
                     end else begin
                        state[i] <= IDLE;
                     end
                  end else begin
                     if (tick) begin
                        tcnt[i] <= tcnt[i] - T_ONE;
                     end
                     if (BIN[i] && pend[i] != P_MAX) begin
                        pend[i] <= pend[i] + 1'b1;
                     end
                  end
               end

               default: begin
                  state[i] <= IDLE;
                  nLOUT[i] <= 1'b1;
               end
            endcase
         end
      end
   end

endmodule

// File: tb/tb_led_pulse_out.sv
module tb_led_pulse_out;

   localparam int DIV  = 4;
   localparam int ONT  = 2;
   localparam int GAPT = 1;
   localparam int PMAX = 3;

   logic       CLK = 1'b0;
   logic       RST = 1'b1;
   logic [2:0] BIN = 3'b000;
   logic [2:0] nLOUT;

   led_pulse_out #(
      .DIV      (DIV),
      .ON_TICKS (ONT),
      .GAP_TICKS(GAPT),
      .PEND_MAX (PMAX)
   ) dut (
      .CLK  (CLK),
      .RST  (RST),
      .BIN  (BIN),
      .nLOUT(nLOUT)
   );

   always #5 CLK = ~CLK;

   int checks = 0;
   int errors = 0;

   // Reference model: edge k (1-based since reset release) is a tick edge iff
   // k % DIV == 0. Each channel keeps absolute deadlines for its ON/GAP ends.
   int k;
   int m_state   [3];  // 0 idle, 1 on, 2 gap
   int m_on_end  [3];
   int m_gap_end [3];
   int m_pend    [3];

   // Activity statistics gathered from the DUT output.
   int         low_cnt   [3];
   int         starts    [3];
   int         last_rise [3];
   logic [2:0] prev;

   function automatic int next_tick(input int e, input int n);
      return ((e / DIV) + 1) * DIV + (n - 1) * DIV;
   endfunction

   function automatic logic [2:0] model_out();
      logic [2:0] o;
      for (int c = 0; c < 3; c++) o[c] = (m_state[c] != 1);
      return o;
   endfunction

   function automatic int model_busy();
      return (m_state[0] != 0 || m_state[1] != 0 || m_state[2] != 0) ? 1 : 0;
   endfunction

   task automatic model_reset();
      k = 0;
      for (int c = 0; c < 3; c++) begin
         m_state[c] = 0; m_on_end[c] = 0; m_gap_end[c] = 0; m_pend[c] = 0;
      end
   endtask

   task automatic model_edge(input logic [2:0] b);
      k++;
      for (int c = 0; c < 3; c++) begin
         case (m_state[c])
            0: if (b[c]) begin
                  m_state[c]  = 1;
                  m_on_end[c] = next_tick(k, ONT);
               end
            1: begin
                  if (b[c] && m_pend[c] < PMAX) m_pend[c]++;
                  if (k == m_on_end[c]) begin
                     m_state[c]   = 2;
                     m_gap_end[c] = next_tick(k, GAPT);
                  end
               end
            default: begin
                  if (k == m_gap_end[c]) begin
                     if (m_pend[c] > 0 || b[c]) begin
                        m_state[c]  = 1;
                        m_on_end[c] = next_tick(k, ONT);
                        if (!b[c]) m_pend[c]--;
                     end else begin
                        m_state[c] = 0;
                     end
                  end else if (b[c] && m_pend[c] < PMAX) begin
                     m_pend[c]++;
                  end
               end
         endcase
      end
   endtask

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      assert (got === exp) else begin
         errors++;
         $error("FAIL %s: observed %0h expected %0h (edge %0d)", tag, got, exp, k);
      end
   endtask

   task automatic clear_stats();
      for (int c = 0; c < 3; c++) begin
         low_cnt[c] = 0; starts[c] = 0; last_rise[c] = -1;
      end
   endtask

   // One clock: drive BIN, advance the model on the edge, compare 1 time unit later.
   task automatic cyc(input logic [2:0] b);
      BIN = b;
      @(posedge CLK);
      if (!RST) model_edge(b);
      #1;
      check("nlout", {29'd0, nLOUT}, {29'd0, model_out()});
      for (int c = 0; c < 3; c++) begin
         if (nLOUT[c] == 1'b0) low_cnt[c]++;
         if (prev[c] == 1'b1 && nLOUT[c] == 1'b0) starts[c]++;
         if (prev[c] == 1'b0 && nLOUT[c] == 1'b1) last_rise[c] = k;
      end
      prev = nLOUT;
   endtask

   task automatic run_quiet();
      int n = 0;
      while (model_busy() != 0 && n < 200) begin
         cyc(3'b000);
         n++;
      end
      cyc(3'b000);
      check("quiet_bound", model_busy(), 0);
   endtask

   // Advance until the next edge index satisfies (k+1) % DIV == ph.
   task automatic align(input int ph);
      int n = 0;
      while (((k + 1) % DIV) != ph && n < 2 * DIV) begin
         cyc(3'b000);
         n++;
      end
      check("align_bound", (k + 1) % DIV, ph);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      logic [2:0] rb;

      // Reset held across edges: outputs high.
      model_reset();
      prev = 3'b111;
      clear_stats();
      repeat (3) @(posedge CLK);
      #1;
      check("reset_hold", {29'd0, nLOUT}, 32'd7);
      #2 RST = 1'b0;

      // Reset mid-ON with a queued event: outputs go high with no clock edge.
      cyc(3'b001);
      cyc(3'b001);
      cyc(3'b000);
      check("mid_on_low", {31'd0, nLOUT[0]}, 32'd0);
      #2 RST = 1'b1;
      #1;
      check("async_reset", {29'd0, nLOUT}, 32'd7);
      model_reset();
      prev = 3'b111;
      repeat (2) @(posedge CLK);
      #1;
      check("reset_hold2", {29'd0, nLOUT}, 32'd7);
      #2 RST = 1'b0;

      // Single event at the edge where cnt goes 0->1; nothing from before reset replays.
      clear_stats();
      cyc(3'b001);
      check("latency", {29'd0, nLOUT}, 32'd6);
      repeat (20) cyc(3'b000);
      check("single_low_cycles", low_cnt[0], 7);
      check("single_intervals", starts[0], 1);
      check("single_rise_edge", last_rise[0], 8);
      check("single_ch1_quiet", low_cnt[1], 0);
      check("single_ch2_quiet", low_cnt[2], 0);

      // Queueing: three extra events during the first ON interval of channel 1.
      align(0);
      clear_stats();
      cyc(3'b010);
      cyc(3'b000);
      cyc(3'b010);
      cyc(3'b000);
      cyc(3'b010);
      cyc(3'b010);
      run_quiet();
      check("queue_intervals", starts[1], 4);
      check("queue_low_cycles", low_cnt[1], 32);

      // Saturation: six extra events while ON yield only three replays.
      align(0);
      clear_stats();
      cyc(3'b100);
      repeat (6) cyc(3'b100);
      run_quiet();
      check("sat_intervals", starts[2], 4);
      check("sat_low_cycles", low_cnt[2], 32);

      // Event on the GAP-expiry edge with nothing queued: ON re-entered there.
      clear_stats();
      cyc(3'b001);
      n = 0;
      while (!(m_state[0] == 2 && k + 1 == m_gap_end[0]) && n < 50) begin
         cyc(3'b000);
         n++;
      end
      check("gap_wait_bound", (n < 50) ? 1 : 0, 1);
      cyc(3'b001);
      check("gap_expiry_reenter", {31'd0, nLOUT[0]}, 32'd0);
      run_quiet();
      check("gap_expiry_intervals", starts[0], 2);

      // Event on the ON-expiry edge: exactly one extra interval after the gap.
      clear_stats();
      cyc(3'b001);
      n = 0;
      while (!(m_state[0] == 1 && k + 1 == m_on_end[0]) && n < 50) begin
         cyc(3'b000);
         n++;
      end
      check("on_wait_bound", (n < 50) ? 1 : 0, 1);
      cyc(3'b001);
      check("on_expiry_high", {31'd0, nLOUT[0]}, 32'd1);
      run_quiet();
      check("on_expiry_intervals", starts[0], 2);

      // Independence: three channels started on different edges of one tick period.
      align(1);
      clear_stats();
      cyc(3'b001);
      cyc(3'b010);
      cyc(3'b100);
      run_quiet();
      check("indep_rise_01", last_rise[0], last_rise[1]);
      check("indep_rise_12", last_rise[1], last_rise[2]);
      check("indep_starts", starts[0] + starts[1] + starts[2], 3);

      // Randomized traffic against the model.
      for (int i = 0; i < 400; i++) begin
         for (int c = 0; c < 3; c++) rb[c] = ($urandom_range(7) == 0);
         cyc(rb);
      end
      run_quiet();

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule
